// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_pkg: opcodes, instruction layout, fetch FSM states        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_stage_pkg;

  localparam int DEF_IW = 16;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd3;
  localparam logic [OPC_W-1:0] OP_LW   = 4'd4;
  localparam logic [OPC_W-1:0] OP_SW   = 4'd5;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'd6;
  localparam logic [OPC_W-1:0] OP_J    = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage: PC, instruction-memory requests, one-entry skid, IF/ID   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              AW       = 8,
  parameter int              IW       = DEF_IW,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [AW-1:0]     imem_addr,
  input  logic [IW-1:0]     imem_rdata,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              redirect,
  input  logic [AW-1:0]     redirect_pc,
  output logic [IW-1:0]     instr,
  output logic [OPC_W-1:0]  opcode,
  output logic [AW-1:0]     instr_pc,
  output logic              instr_valid
);

  localparam logic [AW-1:0] PC_INC = AW'(1);

  fetch_state_e         state, next_state;
  logic [AW-1:0]        pc;
  logic [IW-1:0]        skid;
  logic [AW-1:0]        skid_pc;
  logic                 skid_valid;

  logic                 take_mem;
  logic                 to_skid;
  logic                 from_skid;
  logic                 bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Redirect overrides every per-state action, including the skid drain.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    take_mem   = 1'b0;
    to_skid    = 1'b0;
    from_skid  = 1'b0;
    bubble     = 1'b0;
    case (state)
      ST_IDLE: begin
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !stall) begin
          take_mem = 1'b1;
        end else if (imem_ready && stall) begin
          to_skid    = 1'b1;
          next_state = ST_HOLD;
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          from_skid  = 1'b1;
          next_state = ST_FETCH;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    if (redirect) begin
      next_state = ST_FETCH;
      take_mem   = 1'b0;
      to_skid    = 1'b0;
      from_skid  = 1'b0;
      bubble     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      skid        <= '0;
      skid_pc     <= RESET_PC;
      skid_valid  <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      instr       <= '0;
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
    end else begin
      if (take_mem) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + PC_INC;
      end
      if (to_skid) begin
        skid       <= imem_rdata;
        skid_pc    <= pc;
        skid_valid <= 1'b1;
        pc         <= pc + PC_INC;
      end
      if (bubble) begin
        instr       <= '0;
        instr_valid <= 1'b0;
      end
      if (from_skid) begin
        instr       <= skid;
        instr_pc    <= skid_pc;
        instr_valid <= skid_valid;
        skid_valid  <= 1'b0;
      end
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[IW-1 -: OPC_W];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Self-checking bench for fetch_stage: directed scenarios then random traffic
// against a queue-based model of the fetch pipeline.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  instr_pc;
  logic        instr_valid;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.AW(8), .IW(16), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .opcode      (opcode),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  // Reference model: a program counter, the IF/ID slot, and a queue of
  // fetched-but-undelivered instructions (never more than one entry).
  typedef struct packed { logic [15:0] ins; logic [7:0] pc; } fetched_t;
  logic [15:0] mem [256];
  fetched_t    pending [$];
  int          m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc;
  bit          m_valid;
  bit          m_active;

  task automatic model_reset();
    m_pc = 0; m_instr = '0; m_ipc = '0; m_valid = 0; m_active = 0;
    pending.delete();
  endtask

  function automatic bit model_req();
    return m_active && (pending.size() == 0);
  endfunction

  task automatic model_update(input bit rd, input logic [7:0] rpc, input bit st,
                              input bit rdy, input logic [15:0] data);
    fetched_t f;
    if (rd) begin
      m_pc = int'(rpc); m_instr = '0; m_valid = 0; m_active = 1;
      pending.delete();
    end else if (!m_active) begin
      m_active = 1;
    end else if (pending.size() > 0) begin
      if (!st) begin
        f = pending.pop_front();
        m_instr = f.ins; m_ipc = f.pc; m_valid = 1;
      end
    end else if (rdy) begin
      f.ins = data; f.pc = 8'(m_pc);
      if (st) pending.push_back(f);
      else begin m_instr = f.ins; m_ipc = f.pc; m_valid = 1; end
      m_pc = (m_pc + 1) % 256;
    end else if (!st) begin
      m_instr = '0; m_valid = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("imem_req",    32'(imem_req),    32'(model_req()));
    check("imem_addr",   32'(imem_addr),   32'(m_pc));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr",       32'(instr),       32'(m_instr));
    check("opcode",      32'(opcode),      32'(m_instr[15:12]));
    if (m_valid) check("instr_pc", 32'(instr_pc), 32'(m_ipc));
  endtask

  // Drive one cycle of inputs at the falling edge, let the DUT and model
  // advance on the rising edge, then compare at the next falling edge.
  task automatic step(input bit rd, input logic [7:0] rpc, input bit st, input bit rdy);
    logic [15:0] data;
    data        = rdy ? mem[m_pc] : 16'($urandom);
    redirect    = rd;
    redirect_pc = rpc;
    stall       = st;
    imem_ready  = rdy;
    imem_rdata  = data;
    @(posedge clk);
    model_update(rd, rpc, st, rdy, data);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'h4567; mem[2] = 16'h5ABC; mem[3] = 16'h0321;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b0;

    // Straight-line fetch with a zero-wait memory.
    step(0, 8'h00, 0, 1);
    check("first_req", 32'(imem_req), 32'd1);
    step(0, 8'h00, 0, 1);
    check("op_addi", 32'(opcode), 32'd1);
    step(0, 8'h00, 0, 1);
    check("op_lw", 32'(opcode), 32'd4);
    step(0, 8'h00, 0, 1);
    check("op_sw", 32'(opcode), 32'd5);

    // Stall with a response in flight: held in the skid, then delivered.
    step(0, 8'h00, 1, 1);
    check("hold_instr", 32'(instr), 32'h5ABC);
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 1, 1);
    check("hold_req", 32'(imem_req), 32'd0);
    step(0, 8'h00, 0, 1);
    check("skid_instr", 32'(instr), 32'h0321);
    check("skid_pc", 32'(instr_pc), 32'd3);
    step(0, 8'h00, 0, 1);
    check("resume_pc", 32'(instr_pc), 32'd4);

    // Redirect coinciding with a memory response.
    step(1, 8'h40, 0, 1);
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_addr", 32'(imem_addr), 32'h40);
    step(0, 8'h00, 0, 1);

    // Redirect while holding a buffered instruction under stall.
    step(0, 8'h00, 1, 1);
    step(1, 8'h80, 1, 0);
    check("flush_valid", 32'(instr_valid), 32'd0);
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 0, 1);
    check("flush_pc", 32'(instr_pc), 32'h80);

    // Two memory wait cycles give two bubbles with a stable address.
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    check("bubble_valid", 32'(instr_valid), 32'd0);

    // PC wrap from 0xFF.
    step(1, 8'hFF, 0, 0);
    step(0, 8'h00, 0, 1);
    check("wrap_ipc", 32'(instr_pc), 32'hFF);
    check("wrap_addr", 32'(imem_addr), 32'h00);
    step(0, 8'h00, 0, 1);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    check("areset_valid", 32'(instr_valid), 32'd0);
    check("areset_req", 32'(imem_req), 32'd0);
    check("areset_addr", 32'(imem_addr), 32'd0);
    check("areset_instr", 32'(instr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 19) == 0), 8'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
